rpn_stack_ctrl: RTL and testbench
=================================

# rpn_stack_ctrl

Parametrised Reverse-Polish calculator core: an operand stack of DEPTH entries of WIDTH bits with push, binary operate, and undo. It is driven by debounced single-cycle pulses from the button front end. It replaces the fixed two-operand load-sequencing controller and drives the display mux and result register directly from stack contents.

## Interface
- WIDTH, 16, operand/result width in bits (≥4)
- DEPTH, 4, stack entries (≥2)
- clk  in  1  clock
- Reset  in  1  synchronous, active-high reset
- Enter_pulse  in  1  one-cycle pulse: push data_in
- Op_pulse  in  1  one-cycle pulse: apply OpCode to top two entries
- Undo_pulse  in  1  one-cycle pulse: undo (see Configuration)
- data_in  in  WIDTH  operand to push
- OpCode  in  2  00 ADD, 01 SUB, 10 AND, 11 OR
- top_out  out  WIDTH  stack entry 0 (top), 0 when empty
- next_out  out  WIDTH  stack entry 1, 0 when depth<2
- depth_out  out  $clog2(DEPTH+1)  valid entries
- Status  out  3  state code (Operation)
- busy  out  1  high in any state except IDLE and ERR
- carry  out  1  carry/borrow of last operation
- err_overflow  out  1  push attempted while full
- err_underflow  out  1  operate/undo attempted with insufficient entries

## Operation
- States / Status: IDLE 000, PUSH 001, EXEC 010, UNDO 011, ERR 111.
- Pulses sampled only in IDLE and ERR; ignored while busy. Simultaneous pulses: priority Undo > Op > Enter; lower ones dropped.
- IDLE + Enter: depth==DEPTH → ERR, err_overflow=1, stack unchanged; else → PUSH.
- PUSH: shift stack down, entry0 ← data_in captured at pulse cycle, depth+1 → IDLE.
- IDLE + Op: depth<2 → ERR, err_underflow=1; else → EXEC.
- EXEC: result = f(entry1, entry0); SUB is entry1 − entry0; result modulo 2^WIDTH. Replaces both entries, stack shifts up, depth−1, bottom entry cleared. carry = carry-out (ADD), borrow (SUB), 0 (AND/OR) → IDLE.
- IDLE + Undo → UNDO (behaviour per Configuration) → IDLE.
- ERR: outputs and stack hold. Enter or Undo pulse clears both error flags and returns to IDLE without acting; Op pulse ignored.
- Reset (any state, including mid-PUSH/EXEC): state IDLE, all entries 0, depth_out 0, carry 0, error flags 0, Status 000, busy 0, undo snapshot invalid. The pending operation is discarded.

## Timing
- Pulse at cycle n → state at n+1 → stack/depth/carry updated and visible at n+2, state IDLE at n+2.
- Minimum pulse spacing 2 cycles; a pulse during busy is lost (not queued).
- Error flags assert at n+1 and hold until cleared.
- All outputs registered or decoded from registers; no combinational input→output path.

## Configuration
- RPN_UNDO_EN defined: one-level snapshot recorded on every successful PUSH/EXEC (action type, both consumed operands, prior carry). Undo of a PUSH pops the top entry. Undo of an EXEC pops the result and restores entry1/entry0 and carry. Snapshot invalidated after use; Undo with no valid snapshot → UNDO → IDLE, no change, no error.
- Undefined: Undo pops top entry (depth−1, carry unchanged); Undo with depth==0 → ERR, err_underflow=1. No snapshot logic.

## Structure
- Package rpn_pkg: state enum (3-bit), opcode enum, Status code constants, snapshot action enum.
- Sub-module rpn_alu: combinational, parameter WIDTH; inputs a, b, op; outputs result and carry.
- Stack as register array with shift-down/shift-up; no RAM.

## Test plan
- Reset, push 5, push 3, Op ADD → top_out 8, depth 1, carry 0, Status returns 000 at n+2.
- WIDTH=16: push 0x0002, push 0x0005, SUB → top_out 0xFFFD, carry 1.
- DEPTH=4: five pushes → fifth gives err_overflow=1, Status 111, depth 4, stack intact; Enter → flags clear, IDLE.
- Op with depth 1 → err_underflow=1; simultaneous Enter+Op in IDLE → only EXEC path taken.
- RPN_UNDO_EN: push 7, push 9, OR, Undo → top 9, next 7, depth 2; second Undo → no change. Without macro: same sequence → depth 0 after Undo.
- Reset asserted the cycle after an Op pulse (state EXEC) → all outputs zero next cycle, stack empty.

Source files
------------

// File: rtl/rpn_pkg.sv
// rpn_pkg: shared types for the RPN stack calculator core.
//   state_t     - controller state, encoding doubles as the Status output code
//   opcode_t    - ALU operation select
//   snap_act_t  - action recorded in the undo snapshot (RPN_UNDO_EN builds)
package rpn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_PUSH = 3'b001,
        ST_EXEC = 3'b010,
        ST_UNDO = 3'b011,
        ST_ERR  = 3'b111
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } opcode_t;

    localparam logic [2:0] STATUS_IDLE = 3'b000;
    localparam logic [2:0] STATUS_PUSH = 3'b001;
    localparam logic [2:0] STATUS_EXEC = 3'b010;
    localparam logic [2:0] STATUS_UNDO = 3'b011;
    localparam logic [2:0] STATUS_ERR  = 3'b111;

    typedef enum logic [1:0] {
        SNAP_NONE = 2'b00,
        SNAP_PUSH = 2'b01,
        SNAP_EXEC = 2'b10
    } snap_act_t;

    function automatic logic is_busy(input state_t s);
        return (s != ST_IDLE) && (s != ST_ERR);
    endfunction

endpackage

// File: rtl/rpn_stack_ctrl_if.sv
// rpn_stack_ctrl_if: button-pulse inputs and stack/status outputs of the
// RPN calculator core.
//   master modport - front end / display side (drives pulses, data, opcode)
//   slave modport  - calculator core (drives stack view, depth, status, flags)
interface rpn_stack_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    localparam int DW = $clog2(DEPTH + 1);

    logic             Enter_pulse;
    logic             Op_pulse;
    logic             Undo_pulse;
    logic [WIDTH-1:0] data_in;
    logic [1:0]       OpCode;

    logic [WIDTH-1:0] top_out;
    logic [WIDTH-1:0] next_out;
    logic [DW-1:0]    depth_out;
    logic [2:0]       Status;
    logic             busy;
    logic             carry;
    logic             err_overflow;
    logic             err_underflow;

    modport master (
        output Enter_pulse, Op_pulse, Undo_pulse, data_in, OpCode,
        input  top_out, next_out, depth_out, Status, busy, carry,
               err_overflow, err_underflow
    );

    modport slave (
        input  Enter_pulse, Op_pulse, Undo_pulse, data_in, OpCode,
        output top_out, next_out, depth_out, Status, busy, carry,
               err_overflow, err_underflow
    );

endinterface

// File: rtl/rpn_alu.sv
// rpn_alu: combinational binary operator for the RPN core.
//   i_a      - first operand (stack entry 1)
//   i_b      - second operand (stack entry 0)
//   i_op     - ADD / SUB (i_a - i_b) / AND / OR
//   o_result - result modulo 2^WIDTH
//   o_carry  - carry-out for ADD, borrow for SUB, 0 otherwise
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  opcode_t          i_op,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry
);

    logic [WIDTH:0] w_sum;

    always_comb begin
        w_sum    = '0;
        o_result = '0;
        o_carry  = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_sum    = {1'b0, i_a} + {1'b0, i_b};
                o_result = w_sum[WIDTH-1:0];
                o_carry  = w_sum[WIDTH];
            end
            OP_SUB: begin
                // The extra MSB wraps to 1 exactly when i_a < i_b: the borrow.
                w_sum    = {1'b0, i_a} - {1'b0, i_b};
                o_result = w_sum[WIDTH-1:0];
                o_carry  = w_sum[WIDTH];
            end
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/rpn_stack_ctrl.sv
// rpn_stack_ctrl: Reverse-Polish calculator core with a DEPTH x WIDTH
// register stack, push / binary operate / undo driven by single-cycle pulses.
//   clk   - clock
//   Reset - synchronous, active-high reset
//   bus   - rpn_stack_ctrl_if.slave: pulses, data_in, OpCode in;
//           top_out, next_out, depth_out, Status, busy, carry,
//           err_overflow, err_underflow out
// Build option: define RPN_UNDO_EN for one-level snapshot undo; otherwise
// Undo simply pops the top entry.
//
// state | meaning
// IDLE  | waiting for a pulse
// PUSH  | shift stack down, load captured data_in
// EXEC  | replace top two entries with ALU result
// UNDO  | pop top / restore snapshot
// ERR   | overflow/underflow flagged, waiting for Enter or Undo to clear
module rpn_stack_ctrl
    import rpn_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            Reset,
    rpn_stack_ctrl_if.slave bus
);

    localparam int DW = $clog2(DEPTH + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_stack [DEPTH];
    logic [DW-1:0]    r_depth;
    logic             r_carry;
    logic             r_err_ovf;
    logic             r_err_unf;
    logic [WIDTH-1:0] r_data_cap;
    opcode_t          r_op_cap;

    logic             w_full;
    logic             w_lt2;
    logic             w_ovf_set;
    logic             w_unf_set;
    logic             w_err_clr;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_carry;

`ifdef RPN_UNDO_EN
    snap_act_t        r_snap_act;
    logic [WIDTH-1:0] r_snap_a;
    logic [WIDTH-1:0] r_snap_b;
    logic             r_snap_carry;
`endif

    assign w_full = (r_depth == DW'(DEPTH));
    assign w_lt2  = (r_depth <  DW'(2));

    rpn_alu #(.WIDTH(WIDTH)) u_alu (
        .i_a      (r_stack[1]),
        .i_b      (r_stack[0]),
        .i_op     (r_op_cap),
        .o_result (w_alu_result),
        .o_carry  (w_alu_carry)
    );

    always_ff @(posedge clk) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Pulse priority: Undo > Op > Enter.
    always_comb begin
        w_state_nxt = r_state;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
        w_err_clr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.Undo_pulse) begin
`ifdef RPN_UNDO_EN
                    w_state_nxt = ST_UNDO;
`else
                    if (r_depth == '0) begin
                        w_state_nxt = ST_ERR;
                        w_unf_set   = 1'b1;
                    end else begin
                        w_state_nxt = ST_UNDO;
                    end
`endif
                end else if (bus.Op_pulse) begin
                    if (w_lt2) begin
                        w_state_nxt = ST_ERR;
                        w_unf_set   = 1'b1;
                    end else begin
                        w_state_nxt = ST_EXEC;
                    end
                end else if (bus.Enter_pulse) begin
                    if (w_full) begin
                        w_state_nxt = ST_ERR;
                        w_ovf_set   = 1'b1;
                    end else begin
                        w_state_nxt = ST_PUSH;
                    end
                end
            end
            ST_PUSH, ST_EXEC, ST_UNDO: w_state_nxt = ST_IDLE;
            ST_ERR: begin
                if (bus.Undo_pulse || bus.Enter_pulse) begin
                    w_state_nxt = ST_IDLE;
                    w_err_clr   = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) r_stack[i] <= '0;
            r_depth    <= '0;
            r_carry    <= 1'b0;
            r_err_ovf  <= 1'b0;
            r_err_unf  <= 1'b0;
            r_data_cap <= '0;
            r_op_cap   <= OP_ADD;
`ifdef RPN_UNDO_EN
            r_snap_act   <= SNAP_NONE;
            r_snap_a     <= '0;
            r_snap_b     <= '0;
            r_snap_carry <= 1'b0;
`endif
        end else begin
            if (w_ovf_set) r_err_ovf <= 1'b1;
            if (w_unf_set) r_err_unf <= 1'b1;
            if (w_err_clr) begin
                r_err_ovf <= 1'b0;
                r_err_unf <= 1'b0;
            end

            // Operands are taken at the pulse cycle, i.e. the last IDLE cycle.
            if (r_state == ST_IDLE) begin
                r_data_cap <= bus.data_in;
                r_op_cap   <= opcode_t'(bus.OpCode);
            end

            case (r_state)
                ST_PUSH: begin
                    for (int i = DEPTH - 1; i > 0; i--) r_stack[i] <= r_stack[i-1];
                    r_stack[0] <= r_data_cap;
                    r_depth    <= r_depth + DW'(1);
`ifdef RPN_UNDO_EN
                    r_snap_act <= SNAP_PUSH;
`endif
                end
                ST_EXEC: begin
                    r_stack[0] <= w_alu_result;
                    for (int i = 1; i < DEPTH - 1; i++) r_stack[i] <= r_stack[i+1];
                    r_stack[DEPTH-1] <= '0;
                    r_depth <= r_depth - DW'(1);
                    r_carry <= w_alu_carry;
`ifdef RPN_UNDO_EN
                    r_snap_act   <= SNAP_EXEC;
                    r_snap_a     <= r_stack[1];
                    r_snap_b     <= r_stack[0];
                    r_snap_carry <= r_carry;
`endif
                end
                ST_UNDO: begin
`ifdef RPN_UNDO_EN
                    case (r_snap_act)
                        SNAP_PUSH: begin
                            for (int i = 0; i < DEPTH - 1; i++) r_stack[i] <= r_stack[i+1];
                            r_stack[DEPTH-1] <= '0;
                            r_depth <= r_depth - DW'(1);
                        end
                        SNAP_EXEC: begin
                            // Result is replaced by the two operands, so the
                            // rest of the stack moves down one slot; the
                            // bottom slot was cleared by the EXEC itself.
                            r_stack[0] <= r_snap_b;
                            r_stack[1] <= r_snap_a;
                            for (int i = 2; i < DEPTH; i++) r_stack[i] <= r_stack[i-1];
                            r_depth <= r_depth + DW'(1);
                            r_carry <= r_snap_carry;
                        end
                        default: ;
                    endcase
                    r_snap_act <= SNAP_NONE;
`else
                    for (int i = 0; i < DEPTH - 1; i++) r_stack[i] <= r_stack[i+1];
                    r_stack[DEPTH-1] <= '0;
                    r_depth <= r_depth - DW'(1);
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.top_out       = (r_depth != '0) ? r_stack[0] : '0;
    assign bus.next_out      = w_lt2 ? '0 : r_stack[1];
    assign bus.depth_out     = r_depth;
    assign bus.Status        = r_state;
    assign bus.busy          = is_busy(r_state);
    assign bus.carry         = r_carry;
    assign bus.err_overflow  = r_err_ovf;
    assign bus.err_underflow = r_err_unf;

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
module tb_rpn_stack_ctrl;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int DW = $clog2(D + 1);
    localparam longint unsigned MOD = 64'd1 << W;

    logic clk = 1'b0;
    logic Reset;

    rpn_stack_ctrl_if #(.WIDTH(W), .DEPTH(D)) bus ();

    rpn_stack_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: stack as a queue, top at index 0.
    int unsigned q[$];
    bit m_carry, m_ovf, m_unf, m_err;
`ifdef RPN_UNDO_EN
    int unsigned snap_q[$];
    bit snap_carry, snap_valid;
`endif

    task automatic save_snap();
`ifdef RPN_UNDO_EN
        snap_q     = q;
        snap_carry = m_carry;
        snap_valid = 1'b1;
`endif
    endtask

    task automatic model_reset();
        q.delete();
        m_carry = 0; m_ovf = 0; m_unf = 0; m_err = 0;
`ifdef RPN_UNDO_EN
        snap_q.delete();
        snap_valid = 0;
        snap_carry = 0;
`endif
    endtask

    task automatic model_step(input bit u, input bit o, input bit e,
                              input int unsigned d, input int unsigned op,
                              output int mid);
        longint unsigned a, b, r;
        bit c;
        mid = m_err ? 7 : 0;
        if (m_err) begin
            if (u || e) begin
                m_err = 0; m_ovf = 0; m_unf = 0; mid = 0;
            end
        end else if (u) begin
`ifdef RPN_UNDO_EN
            mid = 3;
            if (snap_valid) begin
                q = snap_q;
                m_carry = snap_carry;
                snap_valid = 0;
            end
`else
            if (q.size() == 0) begin
                mid = 7; m_err = 1; m_unf = 1;
            end else begin
                mid = 3;
                void'(q.pop_front());
            end
`endif
        end else if (o) begin
            if (q.size() < 2) begin
                mid = 7; m_err = 1; m_unf = 1;
            end else begin
                mid = 2;
                save_snap();
                a = q[1]; b = q[0];
                c = 0;
                case (op)
                    0: begin r = (a + b) % MOD; c = (a + b) >= MOD; end
                    1: begin r = (a + MOD - b) % MOD; c = a < b; end
                    2: r = a & b;
                    default: r = a | b;
                endcase
                void'(q.pop_front());
                void'(q.pop_front());
                q.push_front(int'(r));
                m_carry = c;
            end
        end else if (e) begin
            if (q.size() == D) begin
                mid = 7; m_err = 1; m_ovf = 1;
            end else begin
                mid = 1;
                save_snap();
                q.push_front(d);
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".top"},   bus.top_out,   (q.size() > 0) ? q[0] : 0);
        check({tag, ".next"},  bus.next_out,  (q.size() > 1) ? q[1] : 0);
        check({tag, ".depth"}, bus.depth_out, q.size());
        check({tag, ".carry"}, bus.carry,     m_carry);
        check({tag, ".ovf"},   bus.err_overflow,  m_ovf);
        check({tag, ".unf"},   bus.err_underflow, m_unf);
        check({tag, ".status"}, bus.Status,   m_err ? 7 : 0);
        check({tag, ".busy"},  bus.busy,      0);
    endtask

    task automatic clear_inputs();
        bus.Enter_pulse = 0; bus.Op_pulse = 0; bus.Undo_pulse = 0;
    endtask

    // One transaction: pulse(s) for one cycle, check mid state at n+1,
    // optionally fire ignored pulses while busy, check stack at n+2.
    task automatic txn(input string tag, input bit u, input bit o, input bit e,
                       input int unsigned d, input int unsigned op, input bit inject);
        int mid;
        @(negedge clk);
        bus.Undo_pulse = u; bus.Op_pulse = o; bus.Enter_pulse = e;
        bus.data_in = d[W-1:0]; bus.OpCode = op[1:0];
        model_step(u, o, e, d, op, mid);
        @(negedge clk);
        clear_inputs();
        check({tag, ".mid_status"}, bus.Status, mid);
        check({tag, ".mid_busy"}, bus.busy, (mid >= 1 && mid <= 3));
        check({tag, ".mid_ovf"}, bus.err_overflow, m_ovf);
        check({tag, ".mid_unf"}, bus.err_underflow, m_unf);
        if (inject && mid >= 1 && mid <= 3) begin
            bus.Undo_pulse = 1'($urandom); bus.Op_pulse = 1'($urandom);
            bus.Enter_pulse = 1'($urandom);
            bus.data_in = W'($urandom); bus.OpCode = 2'($urandom);
        end
        @(negedge clk);
        clear_inputs();
        check_outputs(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        Reset = 1;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        check_outputs("reset");
        Reset = 0;
    endtask

    initial begin
        Reset = 1;
        clear_inputs();
        bus.data_in = '0; bus.OpCode = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("por");
        Reset = 0;

        // push 5, push 3, ADD
        txn("push5", 0, 0, 1, 5, 0, 0);
        txn("push3", 0, 0, 1, 3, 0, 1);
        txn("add", 0, 1, 0, 0, 0, 0);
        check("add.top_const", bus.top_out, 8);
        check("add.carry_const", bus.carry, 0);
        do_reset();

        // 2 - 5 wraps with borrow
        txn("push2", 0, 0, 1, 2, 0, 0);
        txn("push5b", 0, 0, 1, 5, 0, 0);
        txn("sub", 0, 1, 0, 0, 1, 0);
        check("sub.top_const", bus.top_out, 16'hFFFD);
        check("sub.carry_const", bus.carry, 1);
        do_reset();

        // overflow on fifth push, then clear with Enter
        for (int i = 0; i < 4; i++) txn("fill", 0, 0, 1, 10 + i, 0, 0);
        txn("push_full", 0, 0, 1, 99, 0, 0);
        check("ovf.flag_const", bus.err_overflow, 1);
        check("ovf.status_const", bus.Status, 3'b111);
        txn("err_op_ignored", 0, 1, 0, 0, 0, 0);
        txn("err_clear", 0, 0, 1, 77, 0, 0);
        check("ovf.cleared_const", bus.err_overflow, 0);
        do_reset();

        // underflow, then Enter+Op together takes the Op path only
        txn("push1", 0, 0, 1, 4, 0, 0);
        txn("op_under", 0, 1, 0, 0, 0, 0);
        check("unf.flag_const", bus.err_underflow, 1);
        txn("unf_clear_undo", 1, 0, 0, 0, 0, 0);
        txn("push6", 0, 0, 1, 6, 0, 0);
        txn("enter_op", 0, 1, 1, 1234, 3, 0);
        check("enter_op.depth_const", bus.depth_out, 1);
        do_reset();

        // push 7, push 9, OR, Undo, Undo
        txn("push7", 0, 0, 1, 7, 0, 0);
        txn("push9", 0, 0, 1, 9, 0, 0);
        txn("or", 0, 1, 0, 0, 3, 0);
        txn("undo1", 1, 0, 0, 0, 0, 0);
`ifdef RPN_UNDO_EN
        check("undo1.top_const", bus.top_out, 9);
        check("undo1.next_const", bus.next_out, 7);
        check("undo1.depth_const", bus.depth_out, 2);
`else
        check("undo1.depth_const", bus.depth_out, 0);
`endif
        txn("undo2", 1, 0, 0, 0, 0, 0);

        // Reset while in EXEC discards the operation
        do_reset();
        txn("pa", 0, 0, 1, 100, 0, 0);
        txn("pb", 0, 0, 1, 200, 0, 0);
        @(negedge clk);
        bus.Op_pulse = 1; bus.OpCode = 2'b00;
        @(negedge clk);
        clear_inputs();
        check("exec_before_reset.status", bus.Status, 3'b010);
        Reset = 1;
        @(negedge clk);
        model_reset();
        check_outputs("reset_mid_exec");
        Reset = 0;
        @(negedge clk);
        check_outputs("after_reset_mid_exec");

        // randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            bit u, o, e;
            int unsigned d;
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
                continue;
            end
            u = ($urandom_range(0, 99) < 15);
            o = ($urandom_range(0, 99) < 35);
            e = ($urandom_range(0, 99) < 55);
            case ($urandom_range(0, 3))
                0: d = 0;
                1: d = 16'hFFFF;
                2: d = $urandom_range(0, 15);
                default: d = $urandom_range(0, 65535);
            endcase
            txn("rand", u, o, e, d, $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
